imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the fetch stage's read requests. It holds a word-addressed instruction store that a load port fills, and accepts one fetch request per cycle over a valid/ready handshake. Each request returns one instruction word, in order, after a fixed read latency. A credit-limited response buffer absorbs fetch-side backpressure, and a flush discards every in-flight and buffered response when the pipeline redirects.

## Interface
- AWIDTH, 32, byte-address width
- DWIDTH, 32, instruction word width
- BASE_ADDR, AWIDTH'(IMEM_BASE_ADDR), byte address of word 0
- DEPTH_WORDS, 1024, store size in words, power of two
- LATENCY, 2, request-to-response cycles, legal range 1..4
- OUTSTANDING, 4, maximum accepted-but-unconsumed requests, must be >= 1
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  fetch request valid
- req_ready_o  out  1  request accepted when valid && ready
- req_addr_i  in  AWIDTH  byte address of the requested instruction
- resp_valid_o  out  1  response word available
- resp_ready_i  in  1  fetch consumes the response when valid && ready
- resp_insn_o  out  DWIDTH  instruction word
- resp_addr_o  out  AWIDTH  address of the request being answered
- resp_err_o  out  1  address fault (only when IMEM_BOUNDS_CHECK_EN is defined; otherwise tied to 0)
- flush_i  in  1  discard all outstanding responses
- ld_we_i  in  1  load-port write enable
- ld_idx_i  in  $clog2(DEPTH_WORDS)  word index to write
- ld_data_i  in  DWIDTH  word to write

## Operation
- Word index = (req_addr_i - BASE_ADDR) >> 2, truncated to $clog2(DEPTH_WORDS) bits.
- Storage is an array of DEPTH_WORDS words and is not reset.
- Load port:
  - A load write takes effect at the clock edge.
  - A read accepted in the same cycle as a write to the same index returns the old word.
  - A read accepted in a later cycle returns the new word.
- Read pipeline: LATENCY register stages, each carrying {valid, addr, insn, err}. The stage output enters the response buffer.
- Response buffer:
  - Holds OUTSTANDING entries in FIFO order.
  - The head drives resp_*_o.
  - Entries are never reordered or dropped except by flush.
- Credit counter cnt, range 0..OUTSTANDING:
  - Increments on a request handshake.
  - Decrements on a response handshake.
  - Holds when both occur in the same cycle.
- Request acceptance: req_ready_o = !rst && !flush_i && (cnt < OUTSTANDING). This guarantees the buffer never overflows.
- Flush:
  - Clears every pipeline-stage valid, empties the buffer, and sets cnt = 0 at the next edge.
  - req_ready_o is 0 during the flush cycle, so no request is accepted in that cycle.
  - A response handshake in the flush cycle is still delivered; the data seen that cycle is valid.
- Reset mid-operation: identical to flush, plus req_ready_o is held at 0 while rst is high.

## Timing
- Reset values:
  - req_ready_o 0 while rst is high, 1 in the first cycle after reset.
  - resp_valid_o 0, resp_err_o 0, cnt 0.
  - resp_insn_o and resp_addr_o are don't-care while resp_valid_o is 0.
- A request accepted at edge T makes resp_valid_o = 1 no earlier than the cycle following edge T+LATENCY-1.
  - Example for LATENCY=1: request in cycle 0, response visible in cycle 1.
- Throughput is one response per cycle when resp_ready_i is held at 1 and OUTSTANDING >= LATENCY+1.
- Backpressure: while resp_valid_o && !resp_ready_i, all resp_*_o hold stable.
- Empty buffer: resp_valid_o = 0. The pipeline output is registered into the buffer, with no combinational path from req to resp.
- Full: when cnt == OUTSTANDING, req_ready_o = 0 in the same cycle.
  - A response handshake in that cycle does not raise req_ready_o until the next cycle.
  - This avoids a combinational path from resp_ready_i to req_ready_o.

## Configuration
- IMEM_BOUNDS_CHECK_EN defined:
  - A request with req_addr_i[1:0] != 0, or with req_addr_i outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS), returns resp_insn_o = INSN_NOP and resp_err_o = 1.
  - Latency and ordering are unchanged for faulted requests.
- IMEM_BOUNDS_CHECK_EN undefined:
  - No address checks are made.
  - req_addr_i[1:0] is ignored.
  - The index wraps modulo DEPTH_WORDS.
  - resp_err_o is constant 0.

## Test plan
- Load then stream: load words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193. Then request BASE_ADDR+0, +4, +8, +12 back-to-back with resp_ready_i=1 -> four responses on consecutive cycles with matching addr and data, first response LATENCY cycles after the first accept.
- Backpressure/full: hold resp_ready_i=0 and offer 6 requests with OUTSTANDING=4 -> exactly 4 accepted, req_ready_o=0 after the 4th, resp_*_o stable. Then release resp_ready_i -> 4 responses drain in order and req_ready_o rises one cycle after the first consume.
- Flush: 3 requests in flight, then assert flush_i for one cycle -> no resp_valid_o afterward for those requests, req_ready_o=0 in the flush cycle, cnt=0, and the next request returns normally.
- Read/write collision: in the same cycle, write idx 5 = 0xDEADBEEF and request BASE_ADDR+20 -> the old word is returned. A repeat request in the next cycle returns 0xDEADBEEF.
- Address fault (macro defined): request BASE_ADDR+2 and BASE_ADDR+4*DEPTH_WORDS -> both return 0x00000013 with resp_err_o=1. With the macro undefined, the same requests return word 0 and word 0 (wrap) with err=0.
- Reset mid-stream: assert rst with 2 responses buffered -> resp_valid_o=0 and req_ready_o=0 during reset. After release, req_ready_o=1 and stale data never appears.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch stage.
//
// The load port writes a word-addressed instruction store. Fetch requests
// are accepted over a valid/ready handshake, one per cycle. Each request
// returns one word, in order, LATENCY cycles later. A credit-limited FIFO
// absorbs backpressure from the fetch side. A flush or reset drops every
// in-flight and buffered response.
//
// Optional build macro: IMEM_BOUNDS_CHECK_EN
//   When defined, a request is faulted if its address is misaligned or lies
//   outside the store. A faulted request returns INSN_NOP with resp_err_o = 1.
//   When undefined, the low address bits are ignored, the index wraps modulo
//   DEPTH_WORDS, and resp_err_o is always 0.

package imem_pkg;
  localparam logic [31:0] IMEM_BASE_ADDR = 32'h0000_1000;
  localparam logic [31:0] INSN_NOP       = 32'h0000_0013;
endpackage

module imem_responder
  import imem_pkg::*;
#(
  parameter int                AWIDTH      = 32,
  parameter int                DWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(IMEM_BASE_ADDR),
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 2,
  parameter int                OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [AWIDTH-1:0]              req_addr_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic [DWIDTH-1:0]              resp_insn_o,
  output logic [AWIDTH-1:0]              resp_addr_o,
  output logic                           resp_err_o,
  input  logic                           flush_i,
  input  logic                           ld_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_idx_i,
  input  logic [DWIDTH-1:0]              ld_data_i
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam int CW   = $clog2(OUTSTANDING + 1);
  localparam int PW   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);

  // Instruction store. It has no reset.
  logic [DWIDTH-1:0] mem [DEPTH_WORDS];

  // Handshakes and the credit counter.
  logic          req_fire;
  logic          resp_fire;
  logic [CW-1:0] cnt;

  // Request-side lookup, evaluated in the accept cycle.
  logic [AWIDTH-1:0] offset;
  logic [IDXW-1:0]   rd_idx;
  logic [DWIDTH-1:0] in_insn;
  logic              in_err;

  // Entry that reaches the response buffer at the next edge.
  logic              tail_valid;
  logic [AWIDTH-1:0] tail_addr;
  logic [DWIDTH-1:0] tail_insn;
  logic              tail_err;

  // Response buffer.
  logic [AWIDTH-1:0] fifo_addr [OUTSTANDING];
  logic [DWIDTH-1:0] fifo_insn [OUTSTANDING];
  logic              fifo_err  [OUTSTANDING];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     occ;

  // Ready depends only on the registered credit count, never on resp_ready_i.
  assign req_ready_o = !rst && !flush_i && (cnt < CNT_MAX);
  assign req_fire    = req_valid_i && req_ready_o;

  assign resp_valid_o = (occ != '0);
  assign resp_fire    = resp_valid_o && resp_ready_i;

  assign offset = req_addr_i - BASE_ADDR;
  assign rd_idx = offset[IDXW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  // Flag misaligned or out-of-range requests and substitute a NOP for them.
  always_comb begin
    in_err  = (req_addr_i[1:0] != 2'b00)
           || (req_addr_i < BASE_ADDR)
           || ((offset >> (IDXW + 2)) != '0);
    in_insn = in_err ? DWIDTH'(INSN_NOP) : mem[rd_idx];
  end
`else
  logic unused_addr_bits;

  assign in_err           = 1'b0;
  assign in_insn          = mem[rd_idx];
  assign unused_addr_bits = ^{offset[AWIDTH-1:IDXW+2], offset[1:0]};
`endif

  // Load-port write. A read in the same cycle has already sampled the old word.
  always_ff @(posedge clk) begin
    if (ld_we_i) begin
      mem[ld_idx_i] <= ld_data_i;
    end
  end

  // Credit counter: count accepted-but-unconsumed requests.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      cnt <= '0;
    end else if (req_fire && !resp_fire) begin
      cnt <= cnt + CW'(1);
    end else if (resp_fire && !req_fire) begin
      cnt <= cnt - CW'(1);
    end
  end

  // The buffer write is the last register stage, so LATENCY-1 stages sit in front.
  generate
    if (LATENCY == 1) begin : g_direct
      assign tail_valid = req_fire;
      assign tail_addr  = req_addr_i;
      assign tail_insn  = in_insn;
      assign tail_err   = in_err;
    end else begin : g_pipe
      localparam int NREG = LATENCY - 1;

      logic              pv [NREG];
      logic [AWIDTH-1:0] pa [NREG];
      logic [DWIDTH-1:0] pi [NREG];
      logic              pe [NREG];

      // Stage valid bits are cleared by flush and reset.
      always_ff @(posedge clk) begin
        if (rst || flush_i) begin
          for (int i = 0; i < NREG; i++) begin
            pv[i] <= 1'b0;
          end
        end else begin
          pv[0] <= req_fire;
          for (int i = 1; i < NREG; i++) begin
            pv[i] <= pv[i-1];
          end
        end
      end

      // Stage payload moves every cycle and is qualified by the valid bits.
      always_ff @(posedge clk) begin
        pa[0] <= req_addr_i;
        pi[0] <= in_insn;
        pe[0] <= in_err;
        for (int i = 1; i < NREG; i++) begin
          pa[i] <= pa[i-1];
          pi[i] <= pi[i-1];
          pe[i] <= pe[i-1];
        end
      end

      assign tail_valid = pv[NREG-1];
      assign tail_addr  = pa[NREG-1];
      assign tail_insn  = pi[NREG-1];
      assign tail_err   = pe[NREG-1];
    end
  endgenerate

  // Buffer pointers and occupancy. Credits guarantee a write never overflows.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (tail_valid) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (resp_fire) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      if (tail_valid && !resp_fire) begin
        occ <= occ + CW'(1);
      end else if (!tail_valid && resp_fire) begin
        occ <= occ - CW'(1);
      end
    end
  end

  // Buffer storage. The head stays put under backpressure, so outputs hold.
  always_ff @(posedge clk) begin
    if (tail_valid) begin
      fifo_addr[wr_ptr] <= tail_addr;
      fifo_insn[wr_ptr] <= tail_insn;
      fifo_err[wr_ptr]  <= tail_err;
    end
  end

  assign resp_addr_o = fifo_addr[rd_ptr];
  assign resp_insn_o = fifo_insn[rd_ptr];
  assign resp_err_o  = resp_valid_o && fifo_err[rd_ptr];

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder (LATENCY=2, OUTSTANDING=4, base 0x1000).
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge.

module tb_imem_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] W5   = 32'h0050_0293;
`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_insn_o;
  logic [31:0] resp_addr_o;
  logic        resp_err_o;
  logic        flush_i;
  logic        ld_we_i;
  logic [9:0]  ld_idx_i;
  logic [31:0] ld_data_i;

  int vectors    = 0;
  int miscompares = 0;
  int accepted;

  logic [31:0] words [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};

  imem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_insn_o  (resp_insn_o),
    .resp_addr_o  (resp_addr_o),
    .resp_err_o   (resp_err_o),
    .flush_i      (flush_i),
    .ld_we_i      (ld_we_i),
    .ld_idx_i     (ld_idx_i),
    .ld_data_i    (ld_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expectation and count the result.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the handshake inputs, then wait until mid-cycle to sample.
  task automatic applyStimulus(input logic rv, input logic [31:0] addr, input logic rr,
                               input logic fl, input logic r);
    req_valid_i  = rv;
    req_addr_i   = addr;
    resp_ready_i = rr;
    flush_i      = fl;
    rst          = r;
    @(negedge clk);
  endtask

  task automatic endCycle();
    @(posedge clk);
    #1;
  endtask

  // Watchdog: the run must not outlive its budget.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; resp_ready_i = 1'b0;
    flush_i = 1'b0; ld_we_i = 1'b0; ld_idx_i = '0; ld_data_i = '0;
    endCycle();

    // Reset state.
    applyStimulus(1'b0, BASE, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_req_ready", 64'(req_ready_o), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    checkOutput("rst_resp_err", 64'(resp_err_o), 64'd0);
    checkOutput("rst_cnt", 64'(dut.cnt), 64'd0);
    endCycle();

    // The first cycle after reset accepts requests.
    applyStimulus(1'b0, BASE, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_ready", 64'(req_ready_o), 64'd1);
    endCycle();

    // Load words 0..3 and word 5.
    for (int i = 0; i < 5; i++) begin
      ld_we_i   = 1'b1;
      ld_idx_i  = (i == 4) ? 10'd5 : 10'(i);
      ld_data_i = (i == 4) ? W5 : words[i];
      endCycle();
    end
    ld_we_i = 1'b0;

    // Stream four requests back to back with the consumer always ready.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(k < 4, BASE + 32'(4 * k), 1'b1, 1'b0, 1'b0);
      if (k < 4) checkOutput($sformatf("stream_ready_%0d", k), 64'(req_ready_o), 64'd1);
      checkOutput($sformatf("stream_valid_%0d", k), 64'(resp_valid_o), 64'((k >= 2) && (k < 6)));
      if (k >= 2 && k < 6) begin
        checkOutput($sformatf("stream_insn_%0d", k), 64'(resp_insn_o), 64'(words[k-2]));
        checkOutput($sformatf("stream_addr_%0d", k), 64'(resp_addr_o), 64'(BASE + 32'(4 * (k - 2))));
      end
      endCycle();
    end
    applyStimulus(1'b0, BASE, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_cnt_end", 64'(dut.cnt), 64'd0);
    endCycle();

    // Backpressure: six offers, only four accepted, head held stable.
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, (k < 4) ? BASE + 32'(4 * k) : BASE + 32'd16, 1'b0, 1'b0, 1'b0);
      if (req_valid_i && req_ready_o) accepted++;
      checkOutput($sformatf("bp_ready_%0d", k), 64'(req_ready_o), 64'(k < 4));
      checkOutput($sformatf("bp_valid_%0d", k), 64'(resp_valid_o), 64'(k >= 2));
      if (k >= 2) begin
        checkOutput($sformatf("bp_insn_%0d", k), 64'(resp_insn_o), 64'(words[0]));
        checkOutput($sformatf("bp_addr_%0d", k), 64'(resp_addr_o), 64'(BASE));
      end
      endCycle();
    end
    checkOutput("bp_accepted", 64'(accepted), 64'd4);
    checkOutput("bp_cnt_full", 64'(dut.cnt), 64'd4);

    // Release: drain in order; ready returns one cycle after the first consume.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, BASE, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("drain_ready_%0d", k), 64'(req_ready_o), 64'(k >= 1));
      checkOutput($sformatf("drain_valid_%0d", k), 64'(resp_valid_o), 64'(k < 4));
      if (k < 4) begin
        checkOutput($sformatf("drain_insn_%0d", k), 64'(resp_insn_o), 64'(words[k]));
        checkOutput($sformatf("drain_addr_%0d", k), 64'(resp_addr_o), 64'(BASE + 32'(4 * k)));
      end
      endCycle();
    end

    // Flush with three requests in flight. The offer in the flush cycle must be refused.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k <= 3, BASE + 32'(4 * k), k >= 4, k == 3, 1'b0);
      if (k < 3) checkOutput($sformatf("fl_ready_%0d", k), 64'(req_ready_o), 64'd1);
      if (k == 3) checkOutput("fl_ready_flush", 64'(req_ready_o), 64'd0);
      if (k == 4) checkOutput("fl_cnt", 64'(dut.cnt), 64'd0);
      if (k >= 4) checkOutput($sformatf("fl_valid_%0d", k), 64'(resp_valid_o), 64'd0);
      endCycle();
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k == 0, BASE + 32'd8, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("fl_after_valid_%0d", k), 64'(resp_valid_o), 64'(k == 2));
      if (k == 2) begin
        checkOutput("fl_after_insn", 64'(resp_insn_o), 64'(words[2]));
        checkOutput("fl_after_addr", 64'(resp_addr_o), 64'(BASE + 32'd8));
      end
      endCycle();
    end

    // Read/write collision on index 5.
    for (int k = 0; k < 5; k++) begin
      ld_we_i   = (k == 0);
      ld_idx_i  = 10'd5;
      ld_data_i = 32'hDEAD_BEEF;
      applyStimulus(k < 2, BASE + 32'd20, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("col_valid_%0d", k), 64'(resp_valid_o), 64'((k == 2) || (k == 3)));
      if (k == 2) checkOutput("col_old_word", 64'(resp_insn_o), 64'(W5));
      if (k == 3) checkOutput("col_new_word", 64'(resp_insn_o), 64'(32'hDEAD_BEEF));
      endCycle();
    end
    ld_we_i = 1'b0;

    // Misaligned and past-the-end addresses.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k < 2, (k == 0) ? BASE + 32'd2 : BASE + 32'd4096, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("flt_valid_%0d", k), 64'(resp_valid_o), 64'((k == 2) || (k == 3)));
      if (k == 2 || k == 3) begin
        checkOutput($sformatf("flt_insn_%0d", k), 64'(resp_insn_o), 64'(NOP));
        checkOutput($sformatf("flt_err_%0d", k), 64'(resp_err_o), 64'(EXP_ERR));
        checkOutput($sformatf("flt_addr_%0d", k), 64'(resp_addr_o),
                    64'((k == 2) ? BASE + 32'd2 : BASE + 32'd4096));
      end
      endCycle();
    end

    // Reset with two responses buffered.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(k < 2, BASE + 32'(4 * (k + 1)), k >= 6, 1'b0, (k == 4) || (k == 5));
      if (k == 3) begin
        checkOutput("mrst_buffered_valid", 64'(resp_valid_o), 64'd1);
        checkOutput("mrst_buffered_insn", 64'(resp_insn_o), 64'(words[1]));
        checkOutput("mrst_cnt", 64'(dut.cnt), 64'd2);
      end
      if (k == 4 || k == 5) checkOutput($sformatf("mrst_ready_%0d", k), 64'(req_ready_o), 64'd0);
      if (k >= 5) checkOutput($sformatf("mrst_valid_%0d", k), 64'(resp_valid_o), 64'd0);
      if (k == 6) checkOutput("mrst_ready_after", 64'(req_ready_o), 64'd1);
      endCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
